// File: rtl/vdma_wr_pkg.sv
// VDMA write-channel shared types: FSM state encoding
// and the per-burst length helper.
package vdma_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    WDATA,
    WRESP
  } state_t;

  function automatic logic [31:0] burst_len(
    input logic [31:0] remaining,
    input logic [31:0] max_len
  );
    return (remaining < max_len) ? remaining : max_len;
  endfunction

endpackage

// File: rtl/vdma_stream_to_axi4_wr.sv
// VDMA stream-to-AXI4 write master. Ports: axi_aclk/axi_resetn, frame cmd
// (start, base_addr, frame_beats, busy, done), stream s_*, AXI4 AW/W/B.
module vdma_stream_to_axi4_wr
  import vdma_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_INC   = 8,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  frame_beats,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  output logic                  axi_bready
);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [7:0]            beat_cnt;
  logic [8:0]            nbeats;
  logic [CNT_WIDTH-1:0]  rem_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  w_fire;

  function automatic logic [7:0] len_of(
    input logic [CNT_WIDTH-1:0] r
  );
    logic [31:0] n;
    n = burst_len(32'(r), 32'(BURST_LEN));
    return 8'(n - 32'd1);
  endfunction

  assign nbeats    = {1'b0, axi_awlen} + 9'd1;
  assign rem_next  = remaining - CNT_WIDTH'(nbeats);
  assign addr_next = cur_addr
                   + ADDR_WIDTH'(32'(nbeats) * 32'(ADDR_INC));

  // W channel is a direct pass-through of the stream
  assign axi_wdata  = s_data;
  assign axi_wvalid = (state == WDATA) && s_valid;
  assign s_ready    = (state == WDATA) && axi_wready;
  assign w_fire     = axi_wvalid && axi_wready;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start && frame_beats != '0)
          state_nx = AW;
      AW:
        if (axi_awvalid && axi_awready)
          state_nx = WDATA;
      WDATA:
        if (w_fire && axi_wlast)
          state_nx = WRESP;
      WRESP:
        if (axi_bvalid)
          state_nx = (rem_next == '0) ? IDLE : AW;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      cur_addr    <= '0;
      remaining   <= '0;
      beat_cnt    <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (frame_beats != '0) begin
              cur_addr  <= base_addr;
              remaining <= frame_beats;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        AW: begin
          if (!axi_awvalid) begin
            axi_awvalid <= 1'b1;
            axi_awaddr  <= cur_addr;
            axi_awlen   <= len_of(remaining);
          end else if (axi_awready) begin
            axi_awvalid <= 1'b0;
            beat_cnt    <= axi_awlen;
            axi_wlast   <= (axi_awlen == 8'd0);
          end
        end
        WDATA: begin
          if (w_fire) begin
            if (axi_wlast) begin
              axi_wlast  <= 1'b0;
              axi_bready <= 1'b1;
            end else begin
              beat_cnt  <= beat_cnt - 8'd1;
              axi_wlast <= (beat_cnt == 8'd1);
            end
          end
        end
        WRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            remaining  <= rem_next;
            cur_addr   <= addr_next;
            if (rem_next == '0) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              // next AW goes out the cycle after B
              axi_awvalid <= 1'b1;
              axi_awaddr  <= addr_next;
              axi_awlen   <= len_of(rem_next);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_stream_to_axi4_wr.sv
// Directed bench for vdma_stream_to_axi4_wr with a bus monitor
// and a simple AXI slave / stream source driven from one sequence.
module tb_vdma_stream_to_axi4_wr;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [26:0]  base_addr = '0;
  logic [23:0]  frame_beats = '0;
  logic         busy, done;
  logic [255:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [26:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic         awready = 1'b1;
  logic [255:0] wdata;
  logic         wlast, wvalid;
  logic         wready = 1'b1;
  logic         bvalid = 1'b0;
  logic         bready;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  vdma_stream_to_axi4_wr dut (
    .axi_aclk    (clk),
    .axi_resetn  (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .frame_beats (frame_beats),
    .busy        (busy),
    .done        (done),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .axi_awaddr  (awaddr),
    .axi_awlen   (awlen),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wlast   (wlast),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready)
  );

  function automatic logic [255:0] pat(input int i);
    return {8{32'hA500_0000 ^ 32'(i)}};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // bus monitor, sampled on the falling edge
  logic        clr = 1'b0;
  int          cyc, w_n, wlast_n, data_err, wlast_err;
  int          aw_n, aw_seen, aw_in_wresp, b_n, done_n;
  int          last_b, b_to_aw, bbeat;
  logic [7:0]  cur_len;
  logic        awv_d;
  logic [26:0] aw_addr_q [8];
  logic [7:0]  aw_len_q  [8];

  always @(negedge clk) begin
    if (clr) begin
      cyc <= 0; w_n <= 0; wlast_n <= 0; data_err <= 0;
      wlast_err <= 0; aw_n <= 0; aw_seen <= 0;
      aw_in_wresp <= 0; b_n <= 0; done_n <= 0;
      last_b <= 0; b_to_aw <= -1; bbeat <= 0;
      cur_len <= '0; awv_d <= 1'b0;
    end else if (rst_n) begin
      cyc   <= cyc + 1;
      awv_d <= awvalid;
      if (awvalid && !awv_d && b_n > 0)
        b_to_aw <= cyc - last_b;
      if (awvalid) aw_seen <= aw_seen + 1;
      if (awvalid && bready) aw_in_wresp <= aw_in_wresp + 1;
      if (awvalid && awready) begin
        if (aw_n < 8) begin
          aw_addr_q[aw_n] <= awaddr;
          aw_len_q[aw_n]  <= awlen;
        end
        aw_n    <= aw_n + 1;
        cur_len <= awlen;
        bbeat   <= 0;
      end
      if (wvalid && wready) begin
        if (wdata !== pat(w_n)) data_err <= data_err + 1;
        if (wlast !== (bbeat == int'(cur_len)))
          wlast_err <= wlast_err + 1;
        if (wlast) wlast_n <= wlast_n + 1;
        w_n   <= w_n + 1;
        bbeat <= bbeat + 1;
      end
      if (bvalid && bready) begin
        b_n    <= b_n + 1;
        last_b <= cyc;
      end
      if (done) done_n <= done_n + 1;
    end
  end

  int  total_beats;
  logic seen_done;
  logic busy_at_done;

  task automatic start_frame(input logic [26:0] a,
                             input logic [23:0] n);
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    total_beats = int'(n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = a; frame_beats = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int gap, input int bdelay,
                           input int poke, input int budget);
    int  src = 0;
    int  bcnt = 0;
    logic wfire, bfire;
    seen_done = 1'b0;
    busy_at_done = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      wfire = s_valid && s_ready;
      bfire = bvalid && bready;
      @(posedge clk); #1;
      if (wfire) src++;
      start = 1'b0;
      if (poke != 0 && c == poke) begin
        start = 1'b1; base_addr = '0; frame_beats = 24'd5;
      end
      s_valid = (src < total_beats) &&
                (gap == 0 || $urandom_range(0, 3) != 0);
      s_data  = pat(src);
      wready  = (gap == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      awready = (gap == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bfire) begin
        bvalid = 1'b0;
        bcnt   = 0;
      end else if (bready && !bvalid) begin
        if (bcnt >= bdelay) bvalid = 1'b1;
        else                bcnt++;
      end
      if (done) begin
        seen_done    = 1'b1;
        busy_at_done = busy;
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0; bvalid = 1'b0;
    wready = 1'b1; awready = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_awlen", 64'(awlen), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 64 beats, two full bursts, plus start latency
    start_frame(27'h1000, 24'd64);
    chk("t1_busy_lat", 64'(busy), 64'd1);
    chk("t1_aw_lat1", 64'(awvalid), 64'd0);
    @(posedge clk); #1;
    chk("t1_aw_lat2", 64'(awvalid), 64'd1);
    run_frame(0, 0, 0, 3000);
    chk("t1_done_seen", 64'(seen_done), 64'd1);
    chk("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("t1_aw_n", 64'(aw_n), 64'd2);
    chk("t1_aw0_addr", 64'(aw_addr_q[0]), 64'h1000);
    chk("t1_aw0_len", 64'(aw_len_q[0]), 64'd31);
    chk("t1_aw1_addr", 64'(aw_addr_q[1]), 64'h1100);
    chk("t1_aw1_len", 64'(aw_len_q[1]), 64'd31);
    chk("t1_w_n", 64'(w_n), 64'd64);
    chk("t1_wlast_n", 64'(wlast_n), 64'd2);
    chk("t1_wlast_err", 64'(wlast_err), 64'd0);
    chk("t1_data_err", 64'(data_err), 64'd0);
    chk("t1_done_n", 64'(done_n), 64'd1);
    chk("t1_b_to_aw", 64'(b_to_aw), 64'd1);

    // 40 beats, short tail burst
    start_frame(27'h2000, 24'd40);
    run_frame(0, 0, 0, 3000);
    chk("t2_done_seen", 64'(seen_done), 64'd1);
    chk("t2_aw_n", 64'(aw_n), 64'd2);
    chk("t2_aw0_len", 64'(aw_len_q[0]), 64'd31);
    chk("t2_aw1_addr", 64'(aw_addr_q[1]), 64'h2100);
    chk("t2_aw1_len", 64'(aw_len_q[1]), 64'd7);
    chk("t2_w_n", 64'(w_n), 64'd40);
    chk("t2_b_n", 64'(b_n), 64'd2);
    chk("t2_done_n", 64'(done_n), 64'd1);

    // single-beat frame
    start_frame(27'h300, 24'd1);
    run_frame(0, 0, 0, 1000);
    chk("t3_aw_n", 64'(aw_n), 64'd1);
    chk("t3_aw0_len", 64'(aw_len_q[0]), 64'd0);
    chk("t3_w_n", 64'(w_n), 64'd1);
    chk("t3_wlast_n", 64'(wlast_n), 64'd1);
    chk("t3_wlast_err", 64'(wlast_err), 64'd0);

    // zero-length frame
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 27'h400; frame_beats = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("t4_done_clr", 64'(done), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_aw_seen", 64'(aw_seen), 64'd0);

    // random stalls, slow B, ignored start, address wrap
    start_frame(27'h7FF_FF00, 24'd64);
    run_frame(1, 10, 40, 5000);
    chk("t5_done_seen", 64'(seen_done), 64'd1);
    chk("t5_aw_n", 64'(aw_n), 64'd2);
    chk("t5_aw0_addr", 64'(aw_addr_q[0]), 64'h7FF_FF00);
    chk("t5_aw1_addr_wrap", 64'(aw_addr_q[1]), 64'h0);
    chk("t5_w_n", 64'(w_n), 64'd64);
    chk("t5_wlast_err", 64'(wlast_err), 64'd0);
    chk("t5_data_err", 64'(data_err), 64'd0);
    chk("t5_aw_in_wresp", 64'(aw_in_wresp), 64'd0);
    chk("t5_done_n", 64'(done_n), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_restart", 64'(busy), 64'd0);

    // reset in the middle of the first burst
    start_frame(27'h4_0000, 24'd64);
    begin
      int src = 0;
      logic wfire;
      logic hit = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        wfire = s_valid && s_ready;
        @(posedge clk); #1;
        if (wfire) src++;
        s_valid = 1'b1;
        s_data  = pat(src);
        if (w_n >= 10) begin
          hit = 1'b1;
          break;
        end
      end
      chk("t6_reach_beat10", 64'(hit), 64'd1);
    end
    rst_n = 1'b0;
    wready = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_s_ready", 64'(s_ready), 64'd0);
    chk("t6_rst_wvalid", 64'(wvalid), 64'd0);
    chk("t6_rst_wlast", 64'(wlast), 64'd0);
    chk("t6_rst_awvalid", 64'(awvalid), 64'd0);
    chk("t6_rst_awaddr", 64'(awaddr), 64'd0);
    chk("t6_rst_bready", 64'(bready), 64'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_frame(27'h5_0000, 24'd32);
    run_frame(0, 0, 0, 2000);
    chk("t6_done_seen", 64'(seen_done), 64'd1);
    chk("t6_aw_n", 64'(aw_n), 64'd1);
    chk("t6_aw0_addr", 64'(aw_addr_q[0]), 64'h5_0000);
    chk("t6_aw0_len", 64'(aw_len_q[0]), 64'd31);
    chk("t6_w_n", 64'(w_n), 64'd32);
    chk("t6_data_err", 64'(data_err), 64'd0);
    chk("t6_done_n", 64'(done_n), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
